// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with configurable width and depth, selectable standard or
// first-word-fall-through read, almost-full/almost-empty thresholds, occupancy
// count and sticky overflow/underflow flags. All outputs are registered.
module sync_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 2**ADDR_W-4,
  parameter int AE_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [DATA_W-1:0] din,
  input  logic              ren,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

  // Out-of-range thresholds would make the flags meaningless; stop elaboration.
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH-1) begin : g_bad_ae
    $fatal(1, "sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;

  // Next-state: accept/reject decisions, pointers, occupancy, flags and dout.
  always_comb begin
    wr_acc  = wen && !full_q;
    rd_acc  = ren && !empty_q;

    wptr_d  = wptr_q + {{ADDR_W{1'b0}}, wr_acc};
    rptr_d  = rptr_q + {{ADDR_W{1'b0}}, rd_acc};

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flags track post-operation occupancy so they move with count.
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);

    // Set beats clear when both happen in the same cycle.
    ovf_d = ovf_q;
    if (wen && full_q)    ovf_d = 1'b1;
    else if (clr_err)     ovf_d = 1'b0;
    unf_d = unf_q;
    if (ren && empty_q)   unf_d = 1'b1;
    else if (clr_err)     unf_d = 1'b0;

    dout_d = dout_q;
    if (FWFT != 0) begin
      // Preload the next head into the output register. When the new head is
      // the word being written this very cycle, memory does not hold it yet,
      // so forward din instead.
      if (count_d != '0) begin
        if (wr_acc && (rptr_d == wptr_q)) dout_d = din;
        else                              dout_d = mem_q[rptr_d[ADDR_W-1:0]];
      end
    end else begin
      if (rd_acc) dout_d = mem_q[rptr_q[ADDR_W-1:0]];
    end
  end

  // Control and output registers; reset discards all stored data at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents survive reset and are never cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wptr_q[ADDR_W-1:0]] <= din;
  end

  assign dout         = dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-mode 256-deep instance and an FWFT
// 16-deep instance (AF=8, AE=2), each followed by a queue-based reference.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  // u0: standard read, DEPTH 256
  logic        rst0, wen0, ren0, clr0;
  logic [31:0] din0, dout0;
  logic        full0, empty0, af0, ae0, ovf0, unf0;
  logic [8:0]  cnt0;

  // u1: FWFT, DEPTH 16
  logic        rst1, wen1, ren1, clr1;
  logic [31:0] din1, dout1;
  logic        full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]  cnt1;

  sync_fifo_param #(.DATA_W(32), .ADDR_W(8), .FWFT(0), .AF_THRESH(252), .AE_THRESH(4)) u0 (
    .clk(clk), .rst(rst0), .wen(wen0), .din(din0), .ren(ren0), .clr_err(clr0),
    .dout(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_param #(.DATA_W(32), .ADDR_W(4), .FWFT(1), .AF_THRESH(8), .AE_THRESH(2)) u1 (
    .clk(clk), .rst(rst1), .wen(wen1), .din(din1), .ren(ren1), .clr_err(clr1),
    .dout(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference models: a queue of stored words plus the visible dout and error bits.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] md0, md1;
  bit          mo0, mu0, mo1, mu1;
  bit          a_rd0, a_wr0, a_rd1, a_wr1;

  always @(posedge clk) begin
    if (rst0) begin
      q0.delete(); md0 = 0; mo0 = 0; mu0 = 0;
    end else begin
      a_rd0 = ren0 && q0.size() != 0;
      a_wr0 = wen0 && q0.size() != 256;
      if (wen0 && !a_wr0) mo0 = 1; else if (clr0) mo0 = 0;
      if (ren0 && !a_rd0) mu0 = 1; else if (clr0) mu0 = 0;
      if (a_rd0) md0 = q0.pop_front();
      if (a_wr0) q0.push_back(din0);
    end
  end

  always @(posedge clk) begin
    if (rst1) begin
      q1.delete(); md1 = 0; mo1 = 0; mu1 = 0;
    end else begin
      a_rd1 = ren1 && q1.size() != 0;
      a_wr1 = wen1 && q1.size() != 16;
      if (wen1 && !a_wr1) mo1 = 1; else if (clr1) mo1 = 0;
      if (ren1 && !a_rd1) mu1 = 1; else if (clr1) mu1 = 0;
      if (a_rd1) void'(q1.pop_front());
      if (a_wr1) q1.push_back(din1);
      if (q1.size() != 0) md1 = q1[0];
    end
  end

  // Every-cycle comparison of both instances against their models.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("u0.dout",  dout0, md0);
      chk("u0.count", 32'(cnt0), 32'(q0.size()));
      chk("u0.full",  32'(full0),  32'(q0.size() == 256));
      chk("u0.empty", 32'(empty0), 32'(q0.size() == 0));
      chk("u0.af",    32'(af0),    32'(q0.size() >= 252));
      chk("u0.ae",    32'(ae0),    32'(q0.size() <= 4));
      chk("u0.ovf",   32'(ovf0),   32'(mo0));
      chk("u0.unf",   32'(unf0),   32'(mu0));
      chk("u1.dout",  dout1, md1);
      chk("u1.count", 32'(cnt1), 32'(q1.size()));
      chk("u1.full",  32'(full1),  32'(q1.size() == 16));
      chk("u1.empty", 32'(empty1), 32'(q1.size() == 0));
      chk("u1.af",    32'(af1),    32'(q1.size() >= 8));
      chk("u1.ae",    32'(ae1),    32'(q1.size() <= 2));
      chk("u1.ovf",   32'(ovf1),   32'(mo1));
      chk("u1.unf",   32'(unf1),   32'(mu1));
    end
  end

  // One clock of stimulus; inputs return to idle just after the edge.
  task automatic s0(input bit w, input bit r, input bit c, input logic [31:0] d);
    wen0 = w; ren0 = r; clr0 = c; din0 = d;
    @(posedge clk); #1;
    wen0 = 0; ren0 = 0; clr0 = 0;
  endtask

  task automatic s1(input bit w, input bit r, input bit c, input logic [31:0] d);
    wen1 = w; ren1 = r; clr1 = c; din1 = d;
    @(posedge clk); #1;
    wen1 = 0; ren1 = 0; clr1 = 0;
  endtask

  initial begin
    rst0 = 1; wen0 = 0; ren0 = 0; clr0 = 0; din0 = 0;
    rst1 = 1; wen1 = 0; ren1 = 0; clr1 = 0; din1 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 0; rst1 = 0; chk_en = 1;
    chk("rst.count", 32'(cnt0), 0);
    chk("rst.empty", 32'(empty0), 1);
    chk("rst.ae",    32'(ae0), 1);

    // Reset mid-traffic with 10 words stored and a non-zero dout
    for (int i = 0; i < 12; i++) s0(1, 0, 0, 32'h100 + i);
    s0(0, 1, 0, 0);
    s0(0, 1, 0, 0);
    chk("pre_rst.count", 32'(cnt0), 10);
    chk("pre_rst.dout",  dout0, 32'h101);
    rst0 = 1; wen0 = 1; ren0 = 1; din0 = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 0; wen0 = 0; ren0 = 0;
    chk("mid_rst.count", 32'(cnt0), 0);
    chk("mid_rst.empty", 32'(empty0), 1);
    chk("mid_rst.ae",    32'(ae0), 1);
    chk("mid_rst.full",  32'(full0), 0);
    chk("mid_rst.ovf",   32'(ovf0), 0);
    chk("mid_rst.unf",   32'(unf0), 0);
    chk("mid_rst.dout",  dout0, 0);

    // Fill/drain twice so both pointers wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 256; i++) begin
        s0(1, 0, 0, 32'(r*256 + i));
        if (i == 250) chk("fill.af_251", 32'(af0), 0);
        if (i == 251) chk("fill.af_252", 32'(af0), 1);
      end
      chk("fill.full",  32'(full0), 1);
      chk("fill.count", 32'(cnt0), 256);
      for (int i = 0; i < 256; i++) begin
        s0(0, 1, 0, 0);
        chk("drain.dout", dout0, 32'(r*256 + i));
      end
      chk("drain.empty", 32'(empty0), 1);
    end

    // Overflow / underflow handling
    for (int i = 0; i < 256; i++) s0(1, 0, 0, 32'h1000 + i);
    s0(1, 0, 0, 32'hDEAD);
    chk("ovf.set",   32'(ovf0), 1);
    chk("ovf.count", 32'(cnt0), 256);
    s0(0, 0, 1, 0);
    chk("ovf.clr", 32'(ovf0), 0);
    s0(1, 1, 0, 32'hBEEF);
    chk("full_rw.count", 32'(cnt0), 255);
    chk("full_rw.ovf",   32'(ovf0), 1);
    chk("full_rw.dout",  dout0, 32'h1000);
    s0(0, 0, 1, 0);
    s0(1, 0, 0, 32'h2000);
    s0(1, 0, 1, 32'h2001);
    chk("ovf.set_wins", 32'(ovf0), 1);
    chk("ovf.count2",   32'(cnt0), 256);
    for (int i = 0; i < 255; i++) begin
      s0(0, 1, 0, 0);
      chk("ovf.drain", dout0, 32'h1001 + i);
    end
    s0(0, 1, 0, 0);
    chk("ovf.last", dout0, 32'h2000);
    s0(0, 1, 0, 0);
    chk("unf.set",  32'(unf0), 1);
    chk("unf.dout", dout0, 32'h2000);
    s0(0, 0, 1, 0);
    chk("clr.ovf", 32'(ovf0), 0);
    chk("clr.unf", 32'(unf0), 0);
    s0(1, 1, 0, 32'h3000);
    chk("empty_rw.count", 32'(cnt0), 1);
    chk("empty_rw.unf",   32'(unf0), 1);
    chk("empty_rw.dout",  dout0, 32'h2000);
    s0(0, 1, 0, 0);
    chk("empty_rw.read", dout0, 32'h3000);

    // Steady simultaneous access at count 5
    for (int i = 0; i < 5; i++) s0(1, 0, 0, 32'h4000 + i);
    for (int k = 0; k < 100; k++) begin
      s0(1, 1, 0, 32'h4005 + k);
      chk("simul.dout", dout0, 32'h4000 + k);
    end
    chk("simul.count", 32'(cnt0), 5);

    // FWFT behaviour on u1
    s1(1, 0, 0, 32'hA5A5A5A5);
    chk("fwft.dout0",  dout1, 32'hA5A5A5A5);
    chk("fwft.empty0", 32'(empty1), 0);
    s1(1, 0, 0, 32'h1);
    chk("fwft.hold", dout1, 32'hA5A5A5A5);
    s1(0, 1, 0, 0);
    chk("fwft.dout1", dout1, 32'h1);
    s1(0, 1, 0, 0);
    chk("fwft.empty1", 32'(empty1), 1);
    chk("fwft.keep",   dout1, 32'h1);

    // Threshold sweep up and down (AF=8, AE=2, DEPTH=16)
    for (int n = 1; n <= 16; n++) begin
      s1(1, 0, 0, 32'(n));
      chk("sweep_up.ae", 32'(ae1), 32'(n <= 2));
      chk("sweep_up.af", 32'(af1), 32'(n >= 8));
      chk("sweep_up.dout", dout1, 32'h1);
    end
    chk("sweep.full", 32'(full1), 1);
    for (int n = 15; n >= 0; n--) begin
      s1(0, 1, 0, 0);
      chk("sweep_dn.ae", 32'(ae1), 32'(n <= 2));
      chk("sweep_dn.af", 32'(af1), 32'(n >= 8));
      if (n > 0) chk("sweep_dn.dout", dout1, 32'(16 - n + 1));
    end
    chk("sweep.empty", 32'(empty1), 1);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
